// File: rtl/pe_mult_arbiter.sv
// pe_mult_arbiter
//   Shares one pipelined AW x BW multiplier among N requesters. At most one
//   operand pair is accepted per cycle over a valid/ready handshake. The
//   multiplier inputs are driven from registers. Each issued operation carries
//   a tag down a pipeline that mirrors the multiplier latency, so the product
//   returns to the requester that issued it with a one-hot strobe.
//
//   Build option: define PE_ARB_FIXED_PRIO_EN for fixed priority, where the
//   lowest index wins and no pointer register exists. When it is undefined
//   the arbiter is round-robin.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_n_i      synchronous active-low reset
//   en_i         arbiter enable; 0 blocks new grants, the pipeline still drains
//   req_valid_i  per-requester operand valid
//   req_a_i      packed A operands, requester i at [i*AW +: AW]
//   req_b_i      packed B operands, requester i at [i*BW +: BW]
//   req_ready_o  one-hot accept strobe (combinational)
//   mult_en_o    multiplier enable (registered)
//   mult_a_o     multiplier A (registered)
//   mult_b_o     multiplier B (registered)
//   mult_p_i     multiplier product
//   rsp_valid_o  one-hot product-valid strobe
//   rsp_p_o      product, passed straight through from mult_p_i
//   inflight_o   issued operations whose products have not returned yet
//   idle_o       high when nothing is in flight and mult_en_o is low
module pe_mult_arbiter #(
  parameter int N        = 4,
  parameter int AW       = 8,
  parameter int BW       = 4,
  parameter int MULT_LAT = 1
) (
  input  logic [0:0]       clk_i,
  input  logic [0:0]       rst_n_i,
  input  logic [0:0]       en_i,
  input  logic [N-1:0]     req_valid_i,
  input  logic [N*AW-1:0]  req_a_i,
  input  logic [N*BW-1:0]  req_b_i,
  output logic [N-1:0]     req_ready_o,
  output logic [0:0]       mult_en_o,
  output logic [AW-1:0]    mult_a_o,
  output logic [BW-1:0]    mult_b_o,
  input  logic [AW+BW-1:0] mult_p_i,
  output logic [N-1:0]     rsp_valid_o,
  output logic [AW+BW-1:0] rsp_p_o,
  output logic [2:0]       inflight_o,
  output logic [0:0]       idle_o
);

  localparam int GW    = (N > 1) ? $clog2(N) : 1;
  // One stage for the mult_en register plus one per multiplier cycle.
  localparam int DEPTH = MULT_LAT + 1;

  logic [GW-1:0]   ptr;
  logic            gnt_any;
  logic [GW-1:0]   gnt_idx;
  logic [GW-1:0]   scan_idx;
  logic            hs;

  logic            mult_en_q, mult_en_d;
  logic [AW-1:0]   mult_a_q, mult_a_d;
  logic [BW-1:0]   mult_b_q, mult_b_d;
  logic [DEPTH-1:0] tag_vld_q;
  logic [GW-1:0]   tag_idx_q [DEPTH];
  logic [2:0]      inflight_q, inflight_d;
  logic            rsp_fire;

  // The scan runs from the farthest position back toward the pointer. The
  // last hit is therefore the first valid requester at or above the pointer,
  // wrapping modulo N. The grant is also masked while reset is asserted.
  always_comb begin
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    scan_idx    = '0;
    req_ready_o = '0;
    if (en_i && rst_n_i) begin
      for (int k = N - 1; k >= 0; k--) begin
        scan_idx = GW'((int'(ptr) + k) % N);
        if (req_valid_i[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_any) req_ready_o[gnt_idx] = 1'b1;
  end

  assign hs = gnt_any;

`ifdef PE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [GW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == GW'(N - 1)) ? '0 : gnt_idx + GW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  always_comb begin
    mult_en_d = hs;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;
    if (hs) begin
      mult_a_d = req_a_i[gnt_idx*AW +: AW];
      mult_b_d = req_b_i[gnt_idx*BW +: BW];
    end
  end

  assign rsp_fire = tag_vld_q[DEPTH-1];

  // A simultaneous issue and return leaves the count unchanged.
  always_comb begin
    inflight_d = inflight_q;
    case ({hs, rsp_fire})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mult_en_q  <= 1'b0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      tag_vld_q  <= '0;
      inflight_q <= '0;
      for (int j = 0; j < DEPTH; j++) tag_idx_q[j] <= '0;
    end else begin
      mult_en_q    <= mult_en_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      tag_vld_q    <= {tag_vld_q[DEPTH-2:0], hs};
      tag_idx_q[0] <= gnt_idx;
      for (int j = 1; j < DEPTH; j++) tag_idx_q[j] <= tag_idx_q[j-1];
      inflight_q   <= inflight_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_fire) rsp_valid_o[tag_idx_q[DEPTH-1]] = 1'b1;
  end

  assign rsp_p_o    = mult_p_i;
  assign mult_en_o  = mult_en_q;
  assign mult_a_o   = mult_a_q;
  assign mult_b_o   = mult_b_q;
  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == 3'd0) && !mult_en_q;

endmodule

// File: tb/tb_pe_mult_arbiter.sv
// tb_pe_mult_arbiter
//   Directed bench for pe_mult_arbiter with N=4, AW=8, BW=4 and MULT_LAT=1.
//   A one-cycle multiplier model sits on the mult_* ports. Define
//   PE_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_pe_mult_arbiter;

`ifdef PE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        mult_en;
  logic [7:0]  mult_a;
  logic [3:0]  mult_b;
  logic [11:0] mult_p;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_p;
  logic [2:0]  inflight;
  logic        idle;

  int n_vec = 0;
  int n_err = 0;

  pe_mult_arbiter #(.N(4), .AW(8), .BW(4), .MULT_LAT(1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .mult_en_o   (mult_en),
    .mult_a_o    (mult_a),
    .mult_b_o    (mult_b),
    .mult_p_i    (mult_p),
    .rsp_valid_o (rsp_valid),
    .rsp_p_o     (rsp_p),
    .inflight_o  (inflight),
    .idle_o      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model with a latency of one cycle.
  initial mult_p = '0;
  always @(posedge clk) begin
    if (mult_en) mult_p <= 12'(mult_a) * 12'(mult_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sw_a [3] = '{2, 4, 255};
  int sw_b [3] = '{2, 4, 15};
  int sw_p [3] = '{4, 16, 3825};

  initial begin
    int g;
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;

    // Reset held for two edges while every requester is valid.
    tick();
    tick();
    check_eq("rst_ready",    32'(req_ready), 32'd0);
    check_eq("rst_mult_en",  32'(mult_en),   32'd0);
    check_eq("rst_rsp",      32'(rsp_valid), 32'd0);
    check_eq("rst_idle",     32'(idle),      32'd1);
    check_eq("rst_inflight", 32'(inflight),  32'd0);

    // Single request from requester 0.
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_a[7:0] = 8'd1;
    req_b[3:0] = 4'd1;
    #1;
    check_eq("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("single_en",       32'(mult_en),   32'd1);
    check_eq("single_a",        32'(mult_a),    32'd1);
    check_eq("single_b",        32'(mult_b),    32'd1);
    check_eq("single_inflight", 32'(inflight),  32'd1);
    check_eq("single_rsp_early", 32'(rsp_valid), 32'd0);
    check_eq("single_busy",     32'(idle),      32'd0);
    tick();
    check_eq("single_rsp",     32'(rsp_valid), 32'b0001);
    check_eq("single_p",       32'(rsp_p),     32'd1);
    check_eq("single_en_off",  32'(mult_en),   32'd0);
    tick();
    check_eq("single_rsp_off", 32'(rsp_valid), 32'd0);
    check_eq("single_drained", 32'(inflight),  32'd0);
    check_eq("single_idle",    32'(idle),      32'd1);

    // A reset pulse brings the pointer back to 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Round robin: all four valid for 8 cycles, A=i+1, B=2.
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*4 +: 4] = 4'd2;
    end
    req_valid = 4'hF;
    for (int t = 0; t < 10; t++) begin
      if (t == 8) req_valid = 4'h0;
      #1;
      g = FIXED ? 0 : (t % 4);
      check_eq("rr_ready", 32'(req_ready), (t < 8) ? (32'd1 << g) : 32'd0);
      if (t >= 2) begin
        g = FIXED ? 0 : ((t - 2) % 4);
        check_eq("rr_rsp",   32'(rsp_valid), 32'd1 << g);
        check_eq("rr_p",     32'(rsp_p),     32'(2 * (g + 1)));
      end
      check_eq("rr_inflight", 32'(inflight), (t == 0) ? 32'd0 : (t == 1 || t == 9) ? 32'd1 : 32'd2);
      tick();
    end
    check_eq("rr_idle", 32'(idle), 32'd1);

    // Requester 2 issues three operations back to back.
    for (int t = 0; t < 5; t++) begin
      if (t < 3) begin
        req_a[16 +: 8] = 8'(sw_a[t]);
        req_b[8 +: 4]  = 4'(sw_b[t]);
        req_valid      = 4'b0100;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      check_eq("sw_ready", 32'(req_ready), (t < 3) ? 32'b0100 : 32'd0);
      if (t >= 2) begin
        check_eq("sw_rsp", 32'(rsp_valid), 32'b0100);
        check_eq("sw_p",   32'(rsp_p),     32'(sw_p[t-2]));
      end else begin
        check_eq("sw_rsp_none", 32'(rsp_valid), 32'd0);
      end
      tick();
    end

    // en gating: requester 3 issues, then en drops while requester 1 waits.
    req_a[24 +: 8] = 8'd5;
    req_b[12 +: 4] = 4'd3;
    req_a[8 +: 8]  = 8'd7;
    req_b[4 +: 4]  = 4'd9;
    req_valid = 4'b1000;
    #1;
    check_eq("en_first_ready", 32'(req_ready), 32'b1000);
    tick();
    en        = 1'b0;
    req_valid = 4'b0010;
    #1;
    check_eq("en_block0", 32'(req_ready), 32'd0);
    check_eq("en_issue_a", 32'(mult_a),   32'd5);
    tick();
    check_eq("en_block1",    32'(req_ready), 32'd0);
    check_eq("en_drain_rsp", 32'(rsp_valid), 32'b1000);
    check_eq("en_drain_p",   32'(rsp_p),     32'd15);
    check_eq("en_no_issue",  32'(mult_en),   32'd0);
    tick();
    check_eq("en_block2",    32'(req_ready), 32'd0);
    check_eq("en_idle",      32'(idle),      32'd1);
    tick();
    en = 1'b1;
    #1;
    check_eq("en_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    check_eq("en_release_a", 32'(mult_a), 32'd7);
    check_eq("en_release_b", 32'(mult_b), 32'd9);
    tick();
    check_eq("en_release_rsp", 32'(rsp_valid), 32'b0010);
    check_eq("en_release_p",   32'(rsp_p),     32'd63);
    tick();

    // Reset while the second of two operations is still in flight.
    req_valid = 4'b0011;
    #1;
    check_eq("mid_ready0", 32'(req_ready), 32'b0001);
    tick();
    check_eq("mid_ready1", 32'(req_ready), FIXED ? 32'b0001 : 32'b0010);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    #1;
    check_eq("mid_rsp",      32'(rsp_valid), 32'd0);
    check_eq("mid_inflight", 32'(inflight),  32'd0);
    check_eq("mid_mult_en",  32'(mult_en),   32'd0);
    check_eq("mid_idle",     32'(idle),      32'd1);
    tick();
    check_eq("mid_rsp_late", 32'(rsp_valid), 32'd0);
    req_valid = 4'hF;
    #1;
    check_eq("mid_ptr_zero", 32'(req_ready), 32'b0001);
    req_valid = 4'h0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
